// File: rtl/noc_pkg.sv
// Shared constants for the NoC router datapath: port indices, widths and the
// "no source" select encoding used by the crossbar allocator interface.
package noc_pkg;

  localparam int NOC_NUM_PORTS    = 5;
  localparam int NOC_DATA_W       = 64;
  localparam int NOC_NUM_VC       = 4;
  localparam int NOC_VC_W         = $clog2(NOC_NUM_VC);
  localparam int NOC_CREDIT_DEPTH = 4;
  localparam int NOC_SEL_W        = $clog2(NOC_NUM_PORTS + 1);

  typedef enum logic [NOC_SEL_W-1:0] {
    PORT_N = 3'd0,
    PORT_E = 3'd1,
    PORT_S = 3'd2,
    PORT_W = 3'd3,
    PORT_L = 3'd4
  } port_e;

  localparam logic [NOC_SEL_W-1:0] SEL_NONE = '1;

endpackage

// File: rtl/noc_credit_ctr.sv
// Per-output, per-VC downstream credit counter. Starts full, counts down on
// each forwarded flit and back up on each returned credit, saturating at full.
module noc_credit_ctr
  import noc_pkg::*;
#(
  parameter int DEPTH = NOC_CREDIT_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic consume,
  input  logic credit_ret,
  output logic has_credit,
  output logic overflow
);

  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A simultaneous consume and return cancel out, so only the lone cases move the count
  always_comb begin
    cnt_d    = cnt_q;
    overflow = 1'b0;
    if (consume && !credit_ret) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
    end else if (credit_ret && !consume) begin
      if (cnt_q == FULL) overflow = 1'b1;
      else               cnt_d = cnt_q + 1'b1;
    end
  end

  assign has_credit = (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= FULL;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/noc_xbar_pipe.sv
// Registered NoC crossbar: per-output source select with wormhole locking,
// credit-gated transfers and a one-cycle output register.
module noc_xbar_pipe
  import noc_pkg::*;
#(
  parameter int NUM_PORTS    = NOC_NUM_PORTS,
  parameter int DATA_W       = NOC_DATA_W,
  parameter int NUM_VC       = NOC_NUM_VC,
  parameter int VC_W         = $clog2(NUM_VC),
  parameter int CREDIT_DEPTH = NOC_CREDIT_DEPTH,
  parameter int SEL_W        = $clog2(NUM_PORTS + 1)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS*DATA_W-1:0] in_data,
  input  logic [NUM_PORTS-1:0]        in_valid,
  input  logic [NUM_PORTS*VC_W-1:0]   in_vc,
  input  logic [NUM_PORTS-1:0]        in_tail,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*SEL_W-1:0]  out_sel,
  input  logic [NUM_PORTS-1:0]        out_sel_en,
  output logic [NUM_PORTS*DATA_W-1:0] out_data,
  output logic [NUM_PORTS-1:0]        out_valid,
  output logic [NUM_PORTS*VC_W-1:0]   out_vc,
  input  logic [NUM_PORTS*NUM_VC-1:0] credit_in,
  output logic [1:0]                  err_sticky
);

  // Lock state is a one-hot of the owning input; all-zero means unlocked
  logic [NUM_PORTS-1:0]        lock_q [NUM_PORTS];
  logic [NUM_PORTS-1:0]        lock_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]        src_oh [NUM_PORTS];
  logic [NUM_PORTS-1:0]        xfer;
  logic [NUM_PORTS*NUM_VC-1:0] has_credit, overflow, consume;
  logic                        conflict;

  logic [NUM_PORTS*DATA_W-1:0] out_data_q, out_data_d;
  logic [NUM_PORTS-1:0]        out_valid_q, out_valid_d;
  logic [NUM_PORTS*VC_W-1:0]   out_vc_q, out_vc_d;
  logic [1:0]                  err_q, err_d;

  // Locked outputs claim their input first; unlocked selects then resolve lowest-index-first
  always_comb begin
    logic [NUM_PORTS-1:0] taken, wanted, req;
    taken    = '0;
    wanted   = '0;
    req      = '0;
    conflict = 1'b0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      src_oh[o] = lock_q[o];
      taken     = taken | lock_q[o];
    end
    for (int o = 0; o < NUM_PORTS; o++) begin
      if (lock_q[o] == '0) begin
        req = '0;
        if (out_sel_en[o]) begin
          for (int i = 0; i < NUM_PORTS; i++) begin
            if (out_sel[o*SEL_W +: SEL_W] == SEL_W'(i)) req[i] = 1'b1;
          end
        end
        if ((req & wanted) != '0) conflict = 1'b1;
        wanted = wanted | req;
        if ((req & taken) == '0) begin
          src_oh[o] = req;
          taken     = taken | req;
        end
      end
    end
  end

  for (genvar go = 0; go < NUM_PORTS; go++) begin : g_mux
    logic              flit_valid, flit_tail, flit_credit;
    logic [DATA_W-1:0] flit_data;
    logic [VC_W-1:0]   flit_vc;

    always_comb begin
      flit_valid  = 1'b0;
      flit_tail   = 1'b0;
      flit_data   = '0;
      flit_vc     = '0;
      flit_credit = 1'b0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (src_oh[go][i]) begin
          flit_valid = in_valid[i];
          flit_tail  = in_tail[i];
          flit_data  = in_data[i*DATA_W +: DATA_W];
          flit_vc    = in_vc[i*VC_W +: VC_W];
        end
      end
      for (int v = 0; v < NUM_VC; v++) begin
        if (flit_vc == VC_W'(v)) flit_credit = has_credit[go*NUM_VC + v];
      end
    end

    assign xfer[go] = rst_n & flit_valid & flit_credit;
    assign lock_d[go] = xfer[go] ? (flit_tail ? '0 : src_oh[go]) : lock_q[go];
    assign out_valid_d[go] = xfer[go];
    assign out_data_d[go*DATA_W +: DATA_W] = xfer[go] ? flit_data : out_data_q[go*DATA_W +: DATA_W];
    assign out_vc_d[go*VC_W +: VC_W] = xfer[go] ? flit_vc : out_vc_q[go*VC_W +: VC_W];

    for (genvar gv = 0; gv < NUM_VC; gv++) begin : g_consume
      assign consume[go*NUM_VC + gv] = xfer[go] & (flit_vc == VC_W'(gv));
    end
  end

  for (genvar gc = 0; gc < NUM_PORTS*NUM_VC; gc++) begin : g_credit
    noc_credit_ctr #(
      .DEPTH(CREDIT_DEPTH)
    ) u_ctr (
      .clk        (clk),
      .rst_n      (rst_n),
      .consume    (consume[gc]),
      .credit_ret (credit_in[gc]),
      .has_credit (has_credit[gc]),
      .overflow   (overflow[gc])
    );
  end

  always_comb begin
    in_ready = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (xfer[o] && src_oh[o][i]) in_ready[i] = 1'b1;
      end
    end
  end

  always_comb begin
    err_d    = err_q;
    err_d[0] = err_q[0] | (|overflow);
    err_d[1] = err_q[1] | conflict;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q  <= '0;
      out_valid_q <= '0;
      out_vc_q    <= '0;
      err_q       <= '0;
      for (int o = 0; o < NUM_PORTS; o++) lock_q[o] <= '0;
    end else begin
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_vc_q    <= out_vc_d;
      err_q       <= err_d;
      for (int o = 0; o < NUM_PORTS; o++) lock_q[o] <= lock_d[o];
    end
  end

  assign out_data   = out_data_q;
  assign out_valid  = out_valid_q;
  assign out_vc     = out_vc_q;
  assign err_sticky = err_q;

endmodule

// File: tb/tb_noc_xbar_pipe.sv
// Self-checking bench for noc_xbar_pipe: directed scenarios plus a randomized
// run checked against a packet-level reference model of the crossbar.
module tb_noc_xbar_pipe;

  localparam int NP = 5;
  localparam int DW = 64;
  localparam int NV = 4;
  localparam int VW = 2;
  localparam int SW = 3;
  localparam int CD = 4;

  logic            clk, rst_n;
  logic [NP*DW-1:0] in_data;
  logic [NP-1:0]    in_valid, in_tail, in_ready;
  logic [NP*VW-1:0] in_vc;
  logic [NP*SW-1:0] out_sel;
  logic [NP-1:0]    out_sel_en;
  logic [NP*DW-1:0] out_data;
  logic [NP-1:0]    out_valid;
  logic [NP*VW-1:0] out_vc;
  logic [NP*NV-1:0] credit_in;
  logic [1:0]       err_sticky;

  int total = 0;
  int bad   = 0;

  // Reference model state: credits per output/VC, locked source (-1 = free), sticky errors
  int          m_cred [NP][NV];
  int          m_lock [NP];
  logic [1:0]  m_err;
  logic [NP-1:0] exp_ready, exp_ov;
  logic [DW-1:0] exp_od [NP];
  logic [VW-1:0] exp_ovc [NP];

  noc_xbar_pipe dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_vc      (in_vc),
    .in_tail    (in_tail),
    .in_ready   (in_ready),
    .out_sel    (out_sel),
    .out_sel_en (out_sel_en),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_vc     (out_vc),
    .credit_in  (credit_in),
    .err_sticky (err_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] od(input int o);
    return out_data[o*DW +: DW];
  endfunction

  function automatic logic [VW-1:0] ovc(input int o);
    return out_vc[o*VW +: VW];
  endfunction

  task automatic clear_inputs();
    in_data    = '0;
    in_valid   = '0;
    in_vc      = '0;
    in_tail    = '0;
    out_sel    = '0;
    out_sel_en = '0;
    credit_in  = '0;
  endtask

  task automatic set_in(input int p, input logic v, input logic [DW-1:0] d, input int vc, input logic t);
    in_valid[p]          = v;
    in_data[p*DW +: DW]  = d;
    in_vc[p*VW +: VW]    = VW'(vc);
    in_tail[p]           = t;
  endtask

  task automatic set_sel(input int o, input logic en, input int s);
    out_sel_en[o]        = en;
    out_sel[o*SW +: SW]  = SW'(s);
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int o = 0; o < NP; o++) begin
      m_lock[o]  = -1;
      exp_od[o]  = '0;
      exp_ovc[o] = '0;
      for (int v = 0; v < NV; v++) m_cred[o][v] = CD;
    end
    m_err     = '0;
    exp_ov    = '0;
    exp_ready = '0;
  endtask

  // Evaluate one cycle from the current inputs; leaves post-edge expectations behind
  task automatic model_cycle();
    int  src [NP];
    bit  taken [NP];
    bit  wanted [NP];
    bit  cons [NP][NV];
    int  s, v;
    bit  ret;
    for (int o = 0; o < NP; o++) begin
      taken[o]  = 0;
      wanted[o] = 0;
      for (int k = 0; k < NV; k++) cons[o][k] = 0;
    end
    for (int o = 0; o < NP; o++) begin
      src[o] = m_lock[o];
      if (m_lock[o] >= 0) taken[m_lock[o]] = 1;
    end
    for (int o = 0; o < NP; o++) begin
      if (m_lock[o] < 0 && out_sel_en[o]) begin
        s = int'(out_sel[o*SW +: SW]);
        if (s < NP) begin
          if (wanted[s]) m_err[1] = 1'b1;
          wanted[s] = 1;
          if (!taken[s]) begin
            src[o]   = s;
            taken[s] = 1;
          end
        end
      end
    end
    exp_ready = '0;
    exp_ov    = '0;
    for (int o = 0; o < NP; o++) begin
      if (src[o] >= 0) begin
        s = src[o];
        v = int'(in_vc[s*VW +: VW]);
        if (in_valid[s] && m_cred[o][v] > 0) begin
          exp_ready[s] = 1'b1;
          exp_ov[o]    = 1'b1;
          exp_od[o]    = in_data[s*DW +: DW];
          exp_ovc[o]   = VW'(v);
          cons[o][v]   = 1;
          m_lock[o]    = in_tail[s] ? -1 : s;
        end
      end
    end
    for (int o = 0; o < NP; o++) begin
      for (int k = 0; k < NV; k++) begin
        ret = credit_in[o*NV + k];
        if (cons[o][k] && !ret) m_cred[o][k] = m_cred[o][k] - 1;
        else if (ret && !cons[o][k]) begin
          if (m_cred[o][k] == CD) m_err[0] = 1'b1;
          else m_cred[o][k] = m_cred[o][k] + 1;
        end
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    clear_inputs();
    set_in(1, 1'b1, 64'hDEAD, 0, 1'b1);
    set_sel(0, 1'b1, 1);
    #1 rst_n = 1'b0;
    #2;
    total++; if (in_ready !== 5'b0) begin bad++; $display("[TB] FAIL rst_ready: got %b want 0", in_ready); end
    total++; if (out_valid !== 5'b0) begin bad++; $display("[TB] FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL rst_data: got %h want 0", out_data); end
    total++; if (out_vc !== '0) begin bad++; $display("[TB] FAIL rst_vc: got %h want 0", out_vc); end
    total++; if (err_sticky !== 2'b00) begin bad++; $display("[TB] FAIL rst_err: got %b want 00", err_sticky); end
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear_inputs();
    model_reset();
  endtask

  task automatic test_wormhole();
    logic [DW-1:0] flits [3];
    flits[0] = 64'hA1; flits[1] = 64'hA2; flits[2] = 64'hA3;
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      set_in(1, 1'b1, flits[k], 2, k == 2);
      set_sel(0, 1'b1, k == 0 ? 1 : 3);
      if (k > 0) set_in(3, 1'b1, 64'hBB, 0, 1'b1);
      model_cycle(); #1;
      total++; if (in_ready !== 5'b00010) begin bad++; $display("[TB] FAIL wh_ready_%0d: got %b want 00010", k, in_ready); end
      advance();
      total++; if (out_valid !== 5'b00001) begin bad++; $display("[TB] FAIL wh_valid_%0d: got %b want 00001", k, out_valid); end
      total++; if (od(0) !== flits[k]) begin bad++; $display("[TB] FAIL wh_data_%0d: got %h want %h", k, od(0), flits[k]); end
      total++; if (ovc(0) !== 2'd2) begin bad++; $display("[TB] FAIL wh_vc_%0d: got %0d want 2", k, ovc(0)); end
    end
    clear_inputs();
    set_in(3, 1'b1, 64'hBB, 0, 1'b1);
    set_sel(0, 1'b1, 3);
    model_cycle(); #1;
    total++; if (in_ready !== 5'b01000) begin bad++; $display("[TB] FAIL wh_unlock_ready: got %b want 01000", in_ready); end
    advance();
    total++; if (od(0) !== 64'hBB) begin bad++; $display("[TB] FAIL wh_unlock_data: got %h want bb", od(0)); end
    clear_inputs();
    model_cycle();
    advance();
    total++; if (out_valid !== 5'b0) begin bad++; $display("[TB] FAIL wh_idle_valid: got %b want 0", out_valid); end
    total++; if (od(0) !== 64'hBB) begin bad++; $display("[TB] FAIL wh_idle_hold: got %h want bb", od(0)); end
  endtask

  task automatic test_credit_exhaust();
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      set_in(3, 1'b1, 64'h200 + k, 0, 1'b1);
      set_sel(2, 1'b1, 3);
      model_cycle(); #1;
      total++; if (in_ready[3] !== 1'(k < 4)) begin bad++; $display("[TB] FAIL ce_ready_%0d: got %b want %b", k, in_ready[3], k < 4); end
      advance();
      total++; if (out_valid[2] !== 1'(k < 4)) begin bad++; $display("[TB] FAIL ce_valid_%0d: got %b want %b", k, out_valid[2], k < 4); end
      if (k < 4) begin
        total++; if (od(2) !== 64'h200 + k) begin bad++; $display("[TB] FAIL ce_data_%0d: got %h want %h", k, od(2), 64'h200 + k); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      clear_inputs();
      set_in(3, 1'b1, 64'h2FF, 0, 1'b1);
      set_sel(2, 1'b1, 3);
      if (k == 0) credit_in[2*NV + 0] = 1'b1;
      model_cycle(); #1;
      total++; if (in_ready[3] !== 1'(k == 1)) begin bad++; $display("[TB] FAIL ce_release_%0d: got %b want %b", k, in_ready[3], k == 1); end
      advance();
      total++; if (out_valid[2] !== 1'(k == 1)) begin bad++; $display("[TB] FAIL ce_release_valid_%0d: got %b want %b", k, out_valid[2], k == 1); end
    end
  endtask

  task automatic test_credit_same_cycle();
    for (int k = 0; k < 6; k++) begin
      clear_inputs();
      set_in(1, 1'b1, 64'h300 + k, 1, 1'b1);
      set_sel(2, 1'b1, 1);
      if (k == 2) credit_in[2*NV + 1] = 1'b1;
      model_cycle(); #1;
      total++; if (in_ready[1] !== 1'(k < 5)) begin bad++; $display("[TB] FAIL cs_ready_%0d: got %b want %b", k, in_ready[1], k < 5); end
      advance();
    end
    for (int k = 0; k < 4; k++) begin
      clear_inputs();
      credit_in[2*NV + 1] = 1'b1;
      model_cycle();
      advance();
    end
    total++; if (err_sticky[0] !== 1'b0) begin bad++; $display("[TB] FAIL cs_no_ovf: got %b want 0", err_sticky[0]); end
    clear_inputs();
    credit_in[2*NV + 1] = 1'b1;
    model_cycle();
    advance();
    clear_inputs();
    total++; if (err_sticky[0] !== 1'b1) begin bad++; $display("[TB] FAIL cs_ovf: got %b want 1", err_sticky[0]); end
  endtask

  task automatic test_conflict();
    clear_inputs();
    set_in(4, 1'b1, 64'h4C, 0, 1'b1);
    set_sel(0, 1'b1, 4);
    set_sel(1, 1'b1, 4);
    model_cycle(); #1;
    total++; if (in_ready !== 5'b10000) begin bad++; $display("[TB] FAIL cf_ready: got %b want 10000", in_ready); end
    total++; if (err_sticky[1] !== 1'b0) begin bad++; $display("[TB] FAIL cf_err_before: got %b want 0", err_sticky[1]); end
    advance();
    total++; if (out_valid !== 5'b00001) begin bad++; $display("[TB] FAIL cf_valid: got %b want 00001", out_valid); end
    total++; if (od(0) !== 64'h4C) begin bad++; $display("[TB] FAIL cf_data: got %h want 4c", od(0)); end
    total++; if (err_sticky[1] !== 1'b1) begin bad++; $display("[TB] FAIL cf_err: got %b want 1", err_sticky[1]); end
  endtask

  task automatic test_permutation();
    int src_of [NP];
    src_of[0] = 2; src_of[1] = 3; src_of[2] = 0; src_of[3] = 1; src_of[4] = 4;
    clear_inputs();
    for (int p = 0; p < NP; p++) begin
      set_in(p, 1'b1, 64'h5000 + p, 3, 1'b1);
      set_sel(p, 1'b1, src_of[p]);
    end
    model_cycle(); #1;
    total++; if (in_ready !== 5'b11111) begin bad++; $display("[TB] FAIL pm_ready: got %b want 11111", in_ready); end
    advance();
    total++; if (out_valid !== 5'b11111) begin bad++; $display("[TB] FAIL pm_valid: got %b want 11111", out_valid); end
    for (int o = 0; o < NP; o++) begin
      total++; if (od(o) !== 64'h5000 + src_of[o]) begin bad++; $display("[TB] FAIL pm_data_%0d: got %h want %h", o, od(o), 64'h5000 + src_of[o]); end
      total++; if (ovc(o) !== 2'd3) begin bad++; $display("[TB] FAIL pm_vc_%0d: got %0d want 3", o, ovc(o)); end
    end
  endtask

  task automatic test_reset_mid_packet();
    clear_inputs();
    set_in(1, 1'b1, 64'hE1, 3, 1'b0);
    set_sel(0, 1'b1, 1);
    model_cycle();
    advance();
    total++; if (out_valid[0] !== 1'b1) begin bad++; $display("[TB] FAIL rm_pre_valid: got %b want 1", out_valid[0]); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 5'b0) begin bad++; $display("[TB] FAIL rm_valid: got %b want 0", out_valid); end
    total++; if (out_data !== '0) begin bad++; $display("[TB] FAIL rm_data: got %h want 0", out_data); end
    total++; if (in_ready !== 5'b0) begin bad++; $display("[TB] FAIL rm_ready: got %b want 0", in_ready); end
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    clear_inputs();
    set_in(1, 1'b1, 64'hE2, 3, 1'b0);
    set_in(3, 1'b1, 64'h6A, 0, 1'b1);
    set_sel(0, 1'b1, 3);
    model_cycle(); #1;
    total++; if (in_ready !== 5'b01000) begin bad++; $display("[TB] FAIL rm_new_sel_ready: got %b want 01000", in_ready); end
    advance();
    total++; if (od(0) !== 64'h6A) begin bad++; $display("[TB] FAIL rm_new_sel_data: got %h want 6a", od(0)); end
    for (int k = 0; k < 5; k++) begin
      clear_inputs();
      set_in(3, 1'b1, 64'h700 + k, 0, 1'b1);
      set_sel(2, 1'b1, 3);
      model_cycle(); #1;
      total++; if (in_ready[3] !== 1'(k < 4)) begin bad++; $display("[TB] FAIL rm_credit_%0d: got %b want %b", k, in_ready[3], k < 4); end
      advance();
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      clear_inputs();
      for (int p = 0; p < NP; p++) begin
        set_in(p, 1'($urandom_range(0, 9) < 7), {$urandom, $urandom}, int'($urandom_range(0, NV - 1)), 1'($urandom_range(0, 1)));
        set_sel(p, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)));
      end
      for (int b = 0; b < NP*NV; b++) credit_in[b] = ($urandom_range(0, 5) == 0);
      model_cycle(); #1;
      total++; if (in_ready !== exp_ready) begin bad++; $display("[TB] FAIL rnd_ready c%0d: got %b want %b", c, in_ready, exp_ready); end
      advance();
      total++; if (out_valid !== exp_ov) begin bad++; $display("[TB] FAIL rnd_valid c%0d: got %b want %b", c, out_valid, exp_ov); end
      for (int o = 0; o < NP; o++) begin
        total++; if (od(o) !== exp_od[o]) begin bad++; $display("[TB] FAIL rnd_data c%0d o%0d: got %h want %h", c, o, od(o), exp_od[o]); end
        total++; if (ovc(o) !== exp_ovc[o]) begin bad++; $display("[TB] FAIL rnd_vc c%0d o%0d: got %0d want %0d", c, o, ovc(o), exp_ovc[o]); end
      end
      total++; if (err_sticky !== m_err) begin bad++; $display("[TB] FAIL rnd_err c%0d: got %b want %b", c, err_sticky, m_err); end
    end
  endtask

  initial begin
    $display("[TB] starting noc_xbar_pipe bench");
    test_reset();
    test_wormhole();
    test_credit_exhaust();
    test_credit_same_cycle();
    test_conflict();
    test_permutation();
    test_reset_mid_packet();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
